// File: rtl/alu_seq.sv
// Registered ALU for the SAP datapath: single-cycle add/sub/logic ops plus an
// iterative shift-add multiplier, with a held result/flag register and tri-state bus.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    input  logic             i_start,
    input  logic             i_send_result,
    output wire  [WIDTH-1:0] o_bus,
    output logic [3:0]       o_flags,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam int             CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [WIDTH-1:0]   result;
    logic [3:0]         flags;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   b_op;
    logic               cin;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [2*WIDTH-1:0] acc_next;

    // Flag vector {C, Z, N, V}; Z and N always follow the written result.
    function automatic logic [3:0] pack_flags(input logic c, input logic [WIDTH-1:0] r,
                                              input logic v);
        return {c, (r == '0), r[WIDTH-1], v};
    endfunction

    always_comb begin
        b_op = i_b;
        cin  = 1'b0;
        case (i_op)
            OP_SUB: begin b_op = ~i_b; cin = 1'b1;     end
            OP_ADC: begin              cin = flags[3]; end
            OP_SBC: begin b_op = ~i_b; cin = flags[3]; end
            default: ;
        endcase
        sum     = {1'b0, i_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (i_a[WIDTH-1] == b_op[WIDTH-1]) && (alu_res[WIDTH-1] != i_a[WIDTH-1]);
        case (i_op)
            OP_AND: begin alu_res = i_a & i_b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_OR:  begin alu_res = i_a | i_b; alu_c = 1'b0; alu_v = 1'b0; end
            OP_XOR: begin alu_res = i_a ^ i_b; alu_c = 1'b0; alu_v = 1'b0; end
            default: ;
        endcase
    end

    // Multiplicand is pre-shifted each step, so the add is always aligned.
    assign acc_next = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= S_IDLE;
            result <= '0;
            flags  <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_op == OP_MUL) begin
                            mcand  <= {{WIDTH{1'b0}}, i_a};
                            mplier <= i_b;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else begin
                            result <= alu_res;
                            flags  <= pack_flags(alu_c, alu_res, alu_v);
                            state  <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        result <= acc_next[WIDTH-1:0];
                        flags  <= pack_flags(|acc_next[2*WIDTH-1:WIDTH],
                                             acc_next[WIDTH-1:0], 1'b0);
                        state  <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_bus   = i_send_result ? result : {WIDTH{1'bz}};
    assign o_flags = flags;
    assign o_busy  = (state == S_MUL);
    assign o_done  = (state == S_DONE);

endmodule
